// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the IF/MEM unified-memory arbiter.
// Owner and FSM state encodings, plus the legal parameter ranges.
package cpu_mem_pkg;

   typedef enum logic {
      OwnIf   = 1'b0,
      OwnData = 1'b1
   } owner_e;

   typedef enum logic {
      StIdle = 1'b0,
      StWait = 1'b1
   } arb_state_e;

   // Wide enough for any DATA_W up to 512; users slice to DATA_W/8.
   localparam logic [63:0] BE_ALL = '1;

   localparam int unsigned MEM_LAT_MIN    = 1;
   localparam int unsigned MEM_LAT_MAX    = 4;
   localparam int unsigned STARVE_MAX_MIN = 1;
   localparam int unsigned STARVE_MAX_MAX = 15;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requesters.
// Data wins by default; fetch wins when the starvation limit is hit.
module mem_arb_pick (
   input  logic if_req_i,
   input  logic d_req_i,
   input  logic starve_hit_i,
   output logic pick_if_o,
   output logic pick_d_o
);

   logic force_if;

   always_comb begin
      force_if  = starve_hit_i & if_req_i;
      pick_if_o = if_req_i & (force_if | ~d_req_i);
      pick_d_o  = d_req_i & ~force_if;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data.
// Tracks fixed read latency and produces grants, response pulses and stalls.
module mem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                stall_if,
   output logic                stall_mem
);

   localparam int unsigned BE_W       = DATA_W / 8;
   localparam logic [1:0]  LAT_M1     = 2'(MEM_LAT - 1);
   localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

   if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX ||
       STARVE_MAX < STARVE_MAX_MIN || STARVE_MAX > STARVE_MAX_MAX) begin : g_bad_param
      $error("mem_port_arbiter: MEM_LAT or STARVE_MAX out of range");
   end

   arb_state_e  state_q, state_d;
   owner_e      owner_q, owner_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [3:0]  starve_q, starve_d;

   logic issue_pt;
   logic resp;
   logic pick_if;
   logic pick_d;

   // Gate with rst so every strobe drops the moment reset asserts.
   assign issue_pt = ~rst & ((state_q == StIdle) | (cnt_q == 2'd0));
   assign resp     = (state_q == StWait) & (cnt_q == 2'd0);

   mem_arb_pick u_pick (
      .if_req_i     (if_req),
      .d_req_i      (d_req),
      .starve_hit_i (starve_q == STARVE_LIM),
      .pick_if_o    (pick_if),
      .pick_d_o     (pick_d)
   );

   always_comb begin
      if_gnt    = issue_pt & pick_if;
      d_gnt     = issue_pt & pick_d;
      if_rvalid = resp & (owner_q == OwnIf);
      d_rvalid  = resp & (owner_q == OwnData);
      if_rdata  = mem_rdata;
      d_rdata   = mem_rdata;
      stall_if  = ~rst & if_req & ~if_gnt;
      stall_mem = ~rst & d_req & ~d_gnt;
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      if (d_gnt) begin
         mem_en    = 1'b1;
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         mem_be    = d_be;
      end else if (if_gnt) begin
         mem_en    = 1'b1;
         mem_addr  = if_addr;
         mem_be    = BE_ALL[BE_W-1:0];
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      cnt_d    = cnt_q;
      starve_d = starve_q;

      if (issue_pt) begin
         if (if_gnt | d_gnt) begin
            state_d = StWait;
            owner_d = d_gnt ? OwnData : OwnIf;
            cnt_d   = LAT_M1;
         end else begin
            state_d = StIdle;
         end
      end else if (state_q == StWait) begin
         cnt_d = cnt_q - 2'd1;
      end

      // Only consecutive lost arbitrations with fetch still waiting count.
      if (!if_req || if_gnt) begin
         starve_d = 4'd0;
      end else if (d_gnt && starve_q != STARVE_LIM) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         owner_q  <= OwnIf;
         cnt_q    <= 2'd0;
         starve_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiter instances (latency 1 and 3) on shared stimulus,
// table vectors for single-cycle arbitration plus sequences for multi-cycle cases.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic [31:0] mem_rdata;

   logic        if_gnt_1, if_rvalid_1, d_gnt_1, d_rvalid_1, mem_en_1, mem_we_1;
   logic        stall_if_1, stall_mem_1;
   logic [31:0] if_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1;
   logic [3:0]  mem_be_1;

   logic        if_gnt_3, if_rvalid_3, d_gnt_3, d_rvalid_3, mem_en_3, mem_we_3;
   logic        stall_if_3, stall_mem_3;
   logic [31:0] if_rdata_3, d_rdata_3, mem_addr_3, mem_wdata_3;
   logic [3:0]  mem_be_3;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc       <= cyc + 1;
      mem_rdata <= $urandom;
   end

   mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_1), .if_rvalid(if_rvalid_1),
      .if_rdata(if_rdata_1),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt_1), .d_rvalid(d_rvalid_1), .d_rdata(d_rdata_1),
      .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
      .mem_be(mem_be_1), .mem_rdata(mem_rdata),
      .stall_if(stall_if_1), .stall_mem(stall_mem_1)
   );

   mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_3), .if_rvalid(if_rvalid_3),
      .if_rdata(if_rdata_3),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt_3), .d_rvalid(d_rvalid_3), .d_rdata(d_rdata_3),
      .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
      .mem_be(mem_be_3), .mem_rdata(mem_rdata),
      .stall_if(stall_if_3), .stall_mem(stall_mem_3)
   );

   logic [75:0] all_1, all_3;
   assign all_1 = {if_gnt_1, if_rvalid_1, d_gnt_1, d_rvalid_1, mem_en_1, mem_we_1,
                   mem_addr_1, mem_wdata_1, mem_be_1, stall_if_1, stall_mem_1};
   assign all_3 = {if_gnt_3, if_rvalid_3, d_gnt_3, d_rvalid_3, mem_en_3, mem_we_3,
                   mem_addr_3, mem_wdata_3, mem_be_3, stall_if_3, stall_mem_3};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: each grant pushes the owner and the cycle its response is due.
   typedef struct {
      logic is_d;
      logic is_st;
      int   due;
   } sb_t;
   sb_t q1[$];
   sb_t q3[$];

   always @(negedge clk) begin : mon1
      sb_t e;
      if (rst) begin
         q1.delete();
      end else begin
         if (if_rvalid_1 | d_rvalid_1) begin
            if (q1.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL sb1_spurious: rvalid with nothing outstanding (t=%0t)", $time);
            end else begin
               e = q1.pop_front();
               chk("sb1_resp", {if_rvalid_1, d_rvalid_1, cyc}, {~e.is_d, e.is_d, e.due});
               if (!e.is_st)
                  chk("sb1_rdata", e.is_d ? d_rdata_1 : if_rdata_1, mem_rdata);
            end
         end
         chk("sb1_excl", {if_gnt_1 & d_gnt_1, if_rvalid_1 & d_rvalid_1}, 2'b00);
         if (if_gnt_1 | d_gnt_1) q1.push_back('{d_gnt_1, d_gnt_1 & d_we, cyc + 1});
      end
   end

   always @(negedge clk) begin : mon3
      sb_t e;
      if (rst) begin
         q3.delete();
      end else begin
         if (if_rvalid_3 | d_rvalid_3) begin
            if (q3.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL sb3_spurious: rvalid with nothing outstanding (t=%0t)", $time);
            end else begin
               e = q3.pop_front();
               chk("sb3_resp", {if_rvalid_3, d_rvalid_3, cyc}, {~e.is_d, e.is_d, e.due});
               if (!e.is_st)
                  chk("sb3_rdata", e.is_d ? d_rdata_3 : if_rdata_3, mem_rdata);
            end
         end
         chk("sb3_excl", {if_gnt_3 & d_gnt_3, if_rvalid_3 & d_rvalid_3}, 2'b00);
         if (if_gnt_3 | d_gnt_3) q3.push_back('{d_gnt_3, d_gnt_3 & d_we, cyc + 3});
      end
   end

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        d_req;
      logic        d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [3:0]  d_be;
      logic        e_if_gnt;
      logic        e_d_gnt;
      logic        e_we;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic        e_stall_if;
      logic        e_stall_mem;
   } vec_t;
   vec_t vecs[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_reqs();
      if_req = 1'b0;
      d_req  = 1'b0;
      d_we   = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0,
                  1'b1, 1'b0, 1'b0, 32'h10,  4'hF, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 32'h14, 1'b1, 1'b0, 32'h200, 32'h0,        4'hF,
                  1'b0, 1'b1, 1'b0, 32'h200, 4'hF, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 32'h18, 1'b1, 1'b0, 32'h200, 32'h0,        4'hF,
                  1'b0, 1'b1, 1'b0, 32'h200, 4'hF, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h44,  32'h12345678, 4'h3,
                  1'b0, 1'b1, 1'b1, 32'h44,  4'h3, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 32'h20, 1'b0, 1'b1, 32'h48,  32'h0,        4'hF,
                  1'b0, 1'b0, 1'b0, 32'h0,   4'h0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 32'h24, 1'b1, 1'b1, 32'h4C,  32'hA5A5,     4'hC,
                  1'b0, 1'b1, 1'b1, 32'h4C,  4'hC, 1'b1, 1'b0};

      rst = 1'b1;
      mem_rdata = 32'h0;
      if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
      idle_reqs();
      if_req = 1'b1;
      @(negedge clk);
      chk("reset_out_1", all_1, 76'h0);
      chk("reset_out_3", all_3, 76'h0);
      chk("reset_rdata", {if_rdata_1, d_rdata_3}, {mem_rdata, mem_rdata});
      tick();
      rst = 1'b0;
      idle_reqs();
      tick();

      // Single-cycle arbitration vectors on the latency-1 instance.
      for (int i = 0; i < 6; i++) begin
         if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
         d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_addr = vecs[i].d_addr;
         d_wdata = vecs[i].d_wdata; d_be = vecs[i].d_be;
         @(negedge clk);
         chk($sformatf("vec%0d", i),
             {if_gnt_1, d_gnt_1, mem_en_1, mem_we_1, mem_addr_1, mem_be_1, stall_if_1,
              stall_mem_1},
             {vecs[i].e_if_gnt, vecs[i].e_d_gnt, vecs[i].e_if_gnt | vecs[i].e_d_gnt,
              vecs[i].e_we, vecs[i].e_addr, vecs[i].e_be, vecs[i].e_stall_if,
              vecs[i].e_stall_mem});
         if (vecs[i].e_d_gnt) chk($sformatf("vec%0d_wdata", i), mem_wdata_1, vecs[i].d_wdata);
         tick();
         idle_reqs();
         tick();
      end
      repeat (4) tick();

      // Simultaneous: data first, fetch at the next issue point.
      if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      @(negedge clk);
      chk("simul_first", {d_gnt_1, if_gnt_1, stall_if_1}, 3'b101);
      tick();
      d_req = 1'b0;
      @(negedge clk);
      chk("simul_second", {d_gnt_1, if_gnt_1, mem_addr_1}, {2'b01, 32'h20});
      tick();
      idle_reqs();
      repeat (4) tick();

      // Starvation: four data wins, then fetch is forced through.
      if_req = 1'b1; if_addr = 32'h30; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("starve_issue%0d", k), {d_gnt_1, if_gnt_1},
             (k < 4) ? 2'b10 : 2'b01);
         tick();
      end
      chk("starve_cleared", u_dut1.starve_q, 4'd0);
      idle_reqs();
      repeat (4) tick();

      // Latency 3 store: no grants in the two wait cycles.
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hCAFE; d_be = 4'h3;
      @(negedge clk);
      chk("lat_grant", {d_gnt_3, mem_en_3, mem_we_3, mem_be_3, mem_wdata_3},
          {3'b111, 4'h3, 32'hCAFE});
      tick();
      d_req = 1'b0; d_we = 1'b0; if_req = 1'b1; if_addr = 32'h34;
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk);
         chk($sformatf("lat_wait%0d", k), {if_gnt_3, d_gnt_3, mem_en_3, d_rvalid_3, stall_if_3},
             5'b00001);
         tick();
      end
      @(negedge clk);
      chk("lat_resp", {d_rvalid_3, if_gnt_3, mem_addr_3}, {2'b11, 32'h34});
      tick();
      idle_reqs();
      repeat (4) tick();

      // Flush: fetch raised during a data wait and withdrawn before the issue point.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h84;
      @(negedge clk);
      chk("flush_dgnt", d_gnt_3, 1'b1);
      tick();
      d_req = 1'b0; if_req = 1'b1; if_addr = 32'h40;
      @(negedge clk);
      chk("flush_stall", {if_gnt_3, stall_if_3, mem_en_3}, 3'b010);
      tick();
      if_req = 1'b0;
      @(negedge clk);
      chk("flush_dropped", {if_gnt_3, stall_if_3, mem_en_3}, 3'b000);
      tick();
      @(negedge clk);
      chk("flush_issue", {d_rvalid_3, if_gnt_3, mem_en_3}, 3'b100);
      chk("flush_starve", u_dut3.starve_q, 4'd0);
      tick();
      repeat (3) tick();

      // Reset in the wait cycle after a grant.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h88;
      @(negedge clk);
      chk("rst_pre_gnt", d_gnt_3, 1'b1);
      tick();
      d_req = 1'b0; if_req = 1'b1; if_addr = 32'h50;
      #1 rst = 1'b1;
      #1;
      chk("rst_async_3", all_3, 76'h0);
      chk("rst_async_1", all_1, 76'h0);
      chk("rst_rdata", d_rdata_3, mem_rdata);
      tick();
      rst = 1'b0;
      idle_reqs();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("rst_no_rvalid%0d", k), {if_rvalid_3, d_rvalid_3, if_rvalid_1, d_rvalid_1},
             4'b0000);
         tick();
      end

      chk("sb1_drained", q1.size(), 0);
      chk("sb3_drained", q3.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
